// File: rtl/serial_to_par_rx_pkg.sv
// Shared types for the serial lane: idle/comma value, receiver states, output payload.
package s2p_pkg;

  localparam logic [7:0] IDLE_BYTE = 8'hBC;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    ALIGN  = 2'b01,
    ACTIVE = 2'b10
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       active;
  } rx_out_t;

endpackage

// File: rtl/serial_to_par_rx_if.sv
// Serial lane input plus parallel byte output of the receiver.
interface serial_to_par_rx_if;

  logic       data_in_S2P;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (output data_in_S2P, input data_out, valid_out, active);
  modport slave  (input data_in_S2P, output data_out, valid_out, active);

endinterface

// File: rtl/serial_to_par_rx_shifter.sv
// MSB-first shift register; word_o is the byte completing at the current edge.
module s2p_shifter (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic       data_i,
  output logic [7:0] word_o
);

  // Only the low seven bits of the 8-bit shift register are ever observed.
  logic [6:0] sr_q;

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) sr_q <= '0;
    else          sr_q <= word_o[6:0];
  end

  assign word_o = {sr_q, data_i};

endmodule

// File: rtl/serial_to_par_rx.sv
// Serial-to-parallel receiver: hunts for idle byte alignment, locks, then delivers data bytes.
module serial_to_par_rx
  import s2p_pkg::*;
#(
  parameter int unsigned BC_LOCK = 4
) (
  input logic               clk_8f,
  input logic               reset_L,
  serial_to_par_rx_if.slave bus
);

  localparam int unsigned BC_W = $clog2(BC_LOCK + 1);

  logic [7:0]      word;
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BC_W-1:0] bc_cnt_q, bc_cnt_d;
  logic [BC_W:0]   bc_inc;
  rx_out_t         out_q, out_d;
  logic            is_idle;
  logic            boundary;

  s2p_shifter u_shifter (
    .clk_8f  (clk_8f),
    .reset_L (reset_L),
    .data_i  (bus.data_in_S2P),
    .word_o  (word)
  );

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= HUNT;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    out_d     = out_q;
    is_idle   = (word == IDLE_BYTE);
    boundary  = (bit_cnt_q == 3'd7);
    bc_inc    = (BC_W + 1)'(bc_cnt_q) + (BC_W + 1)'(1);

    case (state_q)
      ALIGN: begin
        if (boundary) begin
          if (is_idle) begin
            bc_cnt_d = (bc_cnt_q == BC_W'(BC_LOCK)) ? bc_cnt_q : BC_W'(bc_inc);
            if (bc_inc == (BC_W + 1)'(BC_LOCK)) state_d = ACTIVE;
          end else begin
            state_d  = HUNT;
            bc_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          if (!is_idle) begin
            out_d.data  = word;
            out_d.valid = 1'b1;
          end else begin
            out_d.valid = 1'b0;
          end
        end
      end
      default: begin
        // Bit-granular search; the unused 2'b11 encoding also lands here.
        if (is_idle) begin
          bit_cnt_d = '0;
          bc_cnt_d  = BC_W'(1);
          state_d   = (BC_LOCK == 1) ? ACTIVE : ALIGN;
        end
      end
    endcase

    out_d.active = (state_d == ACTIVE);
  end

  assign bus.data_out  = out_q.data;
  assign bus.valid_out = out_q.valid;
  assign bus.active    = out_q.active;

endmodule
